// File: rtl/sound_arbiter.sv
// Sound request arbiter: edge-detects game events, arbitrates by fixed priority
// (bad > good > direction) and sequences timed notes for sound_generator.
module sound_arbiter #(
   parameter int unsigned NOTE_LEN  = 16,
   parameter int unsigned CLICK_LEN = 4,
   parameter int unsigned GAP_LEN   = 8,
   parameter int unsigned CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button_i,
   input  logic       goodColl_i,
   input  logic       badColl_i,
   input  logic [3:0] direction_i,
   output logic       toneEn_o,
   output logic [7:0] notePeriod_o,
   output logic [1:0] soundId_o,
   output logic       mute_o,
   output logic       busy_o
);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
   typedef enum logic [1:0] {
      SND_NONE = 2'd0, SND_DIR = 2'd1, SND_GOOD = 2'd2, SND_BAD = 2'd3
   } snd_t;

   state_t           state_q, state_d;
   snd_t             sound_q, sound_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pendBad_q, pendBad_d, pendGood_q, pendGood_d, pendDir_q, pendDir_d;
   logic             prevBtn_q, prevGood_q, prevBad_q;
   logic [3:0]       prevDir_q;
   logic             mute_q, mute_d;
   logic             toneEn_q, toneEn_d, busy_q, busy_d;
   logic [7:0]       period_q, period_d;
   logic [1:0]       soundId_q, soundId_d;

   logic             evBad, evGood, evDir, evBtn;
   logic             pB, pG, pD, start;
   logic [CNT_W-1:0] noteLast;
   logic [1:0]       lastIdx;

   function automatic logic [7:0] note_period(input snd_t s, input logic [1:0] idx);
      logic [7:0] p;
      p = '0;
      case (s)
         SND_BAD:  p = (idx == 2'd0) ? 8'd120 : (idx == 2'd1) ? 8'd160 : 8'd200;
         SND_GOOD: p = (idx == 2'd0) ? 8'd60 : 8'd45;
         SND_DIR:  p = 8'd30;
         default:  p = '0;
      endcase
      return p;
   endfunction

   always_comb begin
      evBad  = badColl_i & ~prevBad_q;
      evGood = goodColl_i & ~prevGood_q;
      evDir  = (direction_i != prevDir_q) && (direction_i != 4'b0000);
      evBtn  = button_i & ~prevBtn_q;
      pB = pendBad_q | evBad;
      pG = pendGood_q | evGood;
      pD = pendDir_q | evDir;
      noteLast = (sound_q == SND_DIR) ? CNT_W'(CLICK_LEN - 1) : CNT_W'(NOTE_LEN - 1);
      lastIdx  = (sound_q == SND_BAD) ? 2'd2 : (sound_q == SND_GOOD) ? 2'd1 : 2'd0;

      state_d    = state_q;
      sound_d    = sound_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      pendBad_d  = pendBad_q;
      pendGood_d = pendGood_q;
      pendDir_d  = pendDir_q;
      mute_d     = mute_q ^ evBtn;
      start      = 1'b0;

      // Muted, or becoming muted or unmuted this cycle: drop everything.
      if (mute_q || mute_d) begin
         state_d    = IDLE;
         sound_d    = SND_NONE;
         idx_d      = '0;
         cnt_d      = '0;
         pendBad_d  = 1'b0;
         pendGood_d = 1'b0;
         pendDir_d  = 1'b0;
      end else begin
         pendBad_d  = pB;
         pendGood_d = pG;
         pendDir_d  = pD;
         case (state_q)
            IDLE: start = 1'b1;
            PLAY: begin
               if (evBad && (sound_q != SND_BAD)) begin
                  sound_d   = SND_BAD;
                  idx_d     = '0;
                  cnt_d     = '0;
                  pendBad_d = 1'b0;
               end else if (cnt_q == noteLast) begin
                  cnt_d = '0;
                  if (idx_q == lastIdx) begin
                     state_d = GAP;
                     sound_d = SND_NONE;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == CNT_W'(GAP_LEN - 1)) start = 1'b1;
               else cnt_d = cnt_q + 1'b1;
            end
            default: start = 1'b1;
         endcase

         if (start) begin
            idx_d = '0;
            cnt_d = '0;
            if (pB) begin
               state_d = PLAY; sound_d = SND_BAD; pendBad_d = 1'b0;
            end else if (pG) begin
               state_d = PLAY; sound_d = SND_GOOD; pendGood_d = 1'b0;
            end else if (pD) begin
               state_d = PLAY; sound_d = SND_DIR; pendDir_d = 1'b0;
            end else begin
               state_d = IDLE; sound_d = SND_NONE;
            end
         end
      end

      // Outputs are derived from next state so they appear one cycle after the event.
      toneEn_d  = (state_d == PLAY);
      period_d  = (state_d == PLAY) ? note_period(sound_d, idx_d) : '0;
      soundId_d = (state_d == PLAY) ? sound_d : SND_NONE;
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sound_q    <= SND_NONE;
         idx_q      <= '0;
         cnt_q      <= '0;
         pendBad_q  <= 1'b0;
         pendGood_q <= 1'b0;
         pendDir_q  <= 1'b0;
         prevBtn_q  <= 1'b0;
         prevGood_q <= 1'b0;
         prevBad_q  <= 1'b0;
         prevDir_q  <= 4'b0000;
         mute_q     <= 1'b0;
         toneEn_q   <= 1'b0;
         period_q   <= '0;
         soundId_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sound_q    <= sound_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         pendBad_q  <= pendBad_d;
         pendGood_q <= pendGood_d;
         pendDir_q  <= pendDir_d;
         prevBtn_q  <= button_i;
         prevGood_q <= goodColl_i;
         prevBad_q  <= badColl_i;
         prevDir_q  <= direction_i;
         mute_q     <= mute_d;
         toneEn_q   <= toneEn_d;
         period_q   <= period_d;
         soundId_q  <= soundId_d;
         busy_q     <= busy_d;
      end
   end

   assign toneEn_o     = toneEn_q;
   assign notePeriod_o = period_q;
   assign soundId_o    = soundId_q;
   assign mute_o       = mute_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboard bench for sound_arbiter: per-cycle expected outputs are queued
// with each stimulus and compared one entry per clock.
module tb_sound_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       button_i, goodColl_i, badColl_i;
   logic [3:0] direction_i;
   logic       toneEn_o, mute_o, busy_o;
   logic [7:0] notePeriod_o;
   logic [1:0] soundId_o;

   logic [12:0] sb_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic        exp_mute = 1'b0;

   always #5 clk = ~clk;

   sound_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .button_i     (button_i),
      .goodColl_i   (goodColl_i),
      .badColl_i    (badColl_i),
      .direction_i  (direction_i),
      .toneEn_o     (toneEn_o),
      .notePeriod_o (notePeriod_o),
      .soundId_o    (soundId_o),
      .mute_o       (mute_o),
      .busy_o       (busy_o)
   );

   // Entry layout: {mute, busy, toneEn, soundId[1:0], period[7:0]}
   task automatic push(input logic busy, input logic en, input logic [1:0] id,
                       input logic [7:0] per, input int n);
      for (int i = 0; i < n; i++) sb_q.push_back({exp_mute, busy, en, id, per});
   endtask

   task automatic push_play(input logic [7:0] per, input logic [1:0] id, input int n);
      push(1'b1, 1'b1, id, per, n);
   endtask

   task automatic push_gap(input int n);
      push(1'b1, 1'b0, 2'd0, 8'd0, n);
   endtask

   task automatic push_idle(input int n);
      push(1'b0, 1'b0, 2'd0, 8'd0, n);
   endtask

   task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got {mute,busy,en,id,per}=%b,%b,%b,%0d,%0d expected %b,%b,%b,%0d,%0d",
                  tag, got[12], got[11], got[10], got[9:8], got[7:0],
                  exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
      end
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            $display("FAIL %s: scoreboard underflow", tag);
            $fatal(1);
         end
         check_eq(tag, {mute_o, busy_o, toneEn_o, soundId_o, notePeriod_o}, sb_q.pop_front());
      end
   endtask

   task automatic run_all(input string tag);
      run(sb_q.size(), tag);
   endtask

   initial begin
      rst = 1'b1; button_i = 1'b0; goodColl_i = 1'b0; badColl_i = 1'b0;
      direction_i = 4'b0000;

      push_idle(2);
      run_all("reset");
      rst = 1'b0;
      push_idle(2);
      run_all("post_reset_idle");

      // Single good collision
      push_play(8'd60, 2'd2, 16); push_play(8'd45, 2'd2, 16); push_gap(8); push_idle(2);
      goodColl_i = 1'b1; run(1, "good_start");
      goodColl_i = 1'b0; run_all("good_seq");

      // Bad and good together: bad first, good straight after the gap
      push_play(8'd120, 2'd3, 16); push_play(8'd160, 2'd3, 16); push_play(8'd200, 2'd3, 16);
      push_gap(8);
      push_play(8'd60, 2'd2, 16); push_play(8'd45, 2'd2, 16); push_gap(8); push_idle(2);
      badColl_i = 1'b1; goodColl_i = 1'b1; run(1, "simul_start");
      badColl_i = 1'b0; goodColl_i = 1'b0; run_all("simul_seq");

      // Direction clicks; return to zero is not an event
      push_play(8'd30, 2'd1, 4); push_gap(8); push_play(8'd30, 2'd1, 4); push_gap(8); push_idle(2);
      direction_i = 4'b0001; run(1, "dir_start");
      direction_i = 4'b0100; run(1, "dir_second");
      direction_i = 4'b0000; run_all("dir_seq");

      // Reset in the middle of a bad sound
      push_play(8'd120, 2'd3, 10);
      badColl_i = 1'b1; run(1, "bad_pre_rst");
      badColl_i = 1'b0; run_all("bad_pre_rst");
      rst = 1'b1; push_idle(2); run_all("reset_mid_sound");
      rst = 1'b0; push_idle(3); run_all("after_reset_mid");

      // Preemption of good by bad at cycle 5 of note 0
      push_play(8'd60, 2'd2, 5);
      goodColl_i = 1'b1; run(1, "preempt_good");
      goodColl_i = 1'b0; run_all("preempt_good");
      push_play(8'd120, 2'd3, 16); push_play(8'd160, 2'd3, 16); push_play(8'd200, 2'd3, 16);
      push_gap(8); push_idle(3);
      badColl_i = 1'b1; run(1, "preempt_bad_start");
      badColl_i = 1'b0; run_all("preempt_bad_seq");

      // Mute mid-bad with a good request pending
      push_play(8'd120, 2'd3, 6);
      badColl_i = 1'b1; run(1, "mute_bad_start");
      badColl_i = 1'b0; goodColl_i = 1'b1; run(1, "mute_good_pend");
      goodColl_i = 1'b0; run_all("mute_bad_play");
      exp_mute = 1'b1;
      push_idle(1);
      button_i = 1'b1; direction_i = 4'b1000; run(1, "mute_on");
      button_i = 1'b0;
      push_idle(4);
      goodColl_i = 1'b1; badColl_i = 1'b1; run(1, "muted_events");
      goodColl_i = 1'b0; badColl_i = 1'b0; direction_i = 4'b0010; run(1, "muted_dir");
      run_all("muted_idle");
      exp_mute = 1'b0;
      push_idle(6);
      button_i = 1'b1; run(1, "mute_off");
      button_i = 1'b0; run_all("unmuted_silent");

      push_play(8'd60, 2'd2, 16); push_play(8'd45, 2'd2, 16); push_gap(8); push_idle(2);
      goodColl_i = 1'b1; run(1, "unmuted_good");
      goodColl_i = 1'b0; run_all("unmuted_good_seq");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
